// File: rtl/cc_level_sequencer.sv
// cc_level_sequencer: clocked level flow for the road/obstacle game.
// Walks banner screen -> level track -> next banner through NUM_LEVELS
// levels, emitting one registered, left-aligned pattern row per accepted
// scroll strobe. Handles pause (blocks strobes) and crash (restarts the
// current level track).
// Optional build macro: CC_LEVELSEQUENCER_LOOP_EN -- after the last level
// the game laps back to the level-1 banner instead of stopping in DONE.
module cc_level_sequencer #(
  parameter int ROW_WIDTH       = 8,
  parameter int NUM_LEVELS      = 3,
  parameter int BANNER_ROWS     = 8,
  parameter int LEVEL_BASE_ROWS = 10,
  parameter int LEVEL_STEP_ROWS = 5,
  parameter int PROG_WIDTH      = 5
) (
  input  logic                  CC_LEVELSEQUENCER_CLOCK_50,
  input  logic                  CC_LEVELSEQUENCER_RESET_InHigh,
  input  logic                  CC_LEVELSEQUENCER_Start_In,
  input  logic                  CC_LEVELSEQUENCER_Advance_In,
  input  logic                  CC_LEVELSEQUENCER_Pause_In,
  input  logic                  CC_LEVELSEQUENCER_Crash_In,
  output logic [ROW_WIDTH-1:0]  CC_LEVELSEQUENCER_Row_OutBus,
  output logic                  CC_LEVELSEQUENCER_RowValid_Out,
  output logic [1:0]            CC_LEVELSEQUENCER_Level_OutBus,
  output logic [PROG_WIDTH-1:0] CC_LEVELSEQUENCER_Progress_OutBus,
  output logic                  CC_LEVELSEQUENCER_Banner_Out,
  output logic                  CC_LEVELSEQUENCER_LevelDone_Out,
  output logic                  CC_LEVELSEQUENCER_GameDone_Out
);

  // S_LEVEL_END is a one-cycle hand-off after the last track row so that
  // LevelDone and GameDone land on consecutive cycles.
  typedef enum logic [2:0] {
    S_IDLE,
    S_BANNER,
    S_LEVEL,
    S_LEVEL_END,
    S_DONE
  } state_t;

  localparam logic [1:0]            LAST_LEVEL  = 2'(NUM_LEVELS);
  localparam logic [PROG_WIDTH-1:0] BANNER_LAST = PROG_WIDTH'(BANNER_ROWS - 1);

  // Pattern tables, first emitted row in the most significant byte.
  localparam logic [8*8-1:0]  BANNER1_TBL = 64'h007C_1010_1030_1000;
  localparam logic [8*8-1:0]  BANNER2_TBL = 64'h007E_2018_0442_3C00;
  localparam logic [8*8-1:0]  BANNER3_TBL = 64'h003C_4202_1C42_3C00;
  localparam logic [8*10-1:0] LEVEL1_TBL  = 80'h2080_2010_4020_8020_1040;
  localparam logic [8*15-1:0] LEVEL2_TBL  = 120'h60A0_6090_C060_60A0_9040_A030_3050_D0;
  localparam logic [8*20-1:0] LEVEL3_TBL  =
    160'hE0B0_E070_E070_B070_B0D0_B070_7070_E0B0_D0E0_D090;

  state_t                  state_q, state_d;
  logic [1:0]              level_q, level_d;
  logic [PROG_WIDTH-1:0]   prog_q, prog_d;
  logic [ROW_WIDTH-1:0]    row_q, row_d;
  logic                    valid_q, valid_d;
  logic                    ldone_q, ldone_d;
  logic                    gdone_q, gdone_d;
  logic                    accept;

  // Look up one 8-bit pattern; indices beyond a table's length read as blank.
  function automatic logic [7:0] pattern(input logic [1:0] lvl, input logic banner,
                                         input logic [PROG_WIDTH-1:0] idx);
    int i;
    logic [7:0] p;
    i = int'(idx);
    p = 8'h00;
    if (banner) begin
      if (i < 8) begin
        case (lvl)
          2'd1:    p = BANNER1_TBL[8*(7-i) +: 8];
          2'd2:    p = BANNER2_TBL[8*(7-i) +: 8];
          2'd3:    p = BANNER3_TBL[8*(7-i) +: 8];
          default: p = 8'h00;
        endcase
      end
    end else begin
      case (lvl)
        2'd1:    if (i < 10) p = LEVEL1_TBL[8*(9-i)  +: 8];
        2'd2:    if (i < 15) p = LEVEL2_TBL[8*(14-i) +: 8];
        2'd3:    if (i < 20) p = LEVEL3_TBL[8*(19-i) +: 8];
        default: p = 8'h00;
      endcase
    end
    return p;
  endfunction

  // Index of the last track row of a level (level n has base + (n-1)*step rows).
  function automatic logic [PROG_WIDTH-1:0] level_last(input logic [1:0] lvl);
    return PROG_WIDTH'(LEVEL_BASE_ROWS + (int'(lvl) - 1) * LEVEL_STEP_ROWS - 1);
  endfunction

  // Left-align an 8-bit pattern in the output row; extra LSBs stay zero.
  function automatic logic [ROW_WIDTH-1:0] place(input logic [7:0] p);
    logic [ROW_WIDTH-1:0] r;
    r = '0;
    r[ROW_WIDTH-1 -: 8] = p;
    return r;
  endfunction

  assign accept = CC_LEVELSEQUENCER_Advance_In & ~CC_LEVELSEQUENCER_Pause_In &
                  ~CC_LEVELSEQUENCER_Crash_In;

  // State and output registers; reset clears everything to the IDLE picture.
  always_ff @(posedge CC_LEVELSEQUENCER_CLOCK_50 or posedge CC_LEVELSEQUENCER_RESET_InHigh) begin
    if (CC_LEVELSEQUENCER_RESET_InHigh) begin
      state_q <= S_IDLE;
      level_q <= 2'd0;
      prog_q  <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      ldone_q <= 1'b0;
      gdone_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      level_q <= level_d;
      prog_q  <= prog_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      ldone_q <= ldone_d;
      gdone_q <= gdone_d;
    end
  end

  // Next-state and next-output decode for the level flow.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    level_d = level_q;
    prog_d  = prog_q;
    row_d   = row_q;
    valid_d = 1'b0;
    ldone_d = 1'b0;
    gdone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CC_LEVELSEQUENCER_Start_In) begin
          state_d = S_BANNER;
          level_d = 2'd1;
          prog_d  = '0;
        end
      end

      S_BANNER: begin
        if (accept) begin
          row_d   = place(pattern(level_q, 1'b1, prog_q));
          valid_d = 1'b1;
          if (prog_q == BANNER_LAST) begin
            prog_d  = '0;
            state_d = S_LEVEL;
          end else begin
            prog_d = prog_q + PROG_WIDTH'(1);
          end
        end
      end

      S_LEVEL: begin
        if (CC_LEVELSEQUENCER_Crash_In) begin
          // Crash restarts the track of the current level with a blank row.
          prog_d = '0;
          row_d  = '0;
        end else if (accept) begin
          row_d   = place(pattern(level_q, 1'b0, prog_q));
          valid_d = 1'b1;
          if (prog_q == level_last(level_q)) begin
            prog_d  = '0;
            ldone_d = 1'b1;
            state_d = S_LEVEL_END;
          end else begin
            prog_d = prog_q + PROG_WIDTH'(1);
          end
        end
      end

      S_LEVEL_END: begin
        if (level_q < LAST_LEVEL) begin
          state_d = S_BANNER;
          level_d = level_q + 2'd1;
        end else begin
          gdone_d = 1'b1;
`ifdef CC_LEVELSEQUENCER_LOOP_EN
          state_d = S_BANNER;
          level_d = 2'd1;
`else
          state_d = S_DONE;
          row_d   = '0;
`endif
        end
      end

      S_DONE: begin
        if (CC_LEVELSEQUENCER_Start_In) begin
          state_d = S_BANNER;
          level_d = 2'd1;
          prog_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign CC_LEVELSEQUENCER_Row_OutBus      = row_q;
  assign CC_LEVELSEQUENCER_RowValid_Out    = valid_q;
  assign CC_LEVELSEQUENCER_Level_OutBus    = level_q;
  assign CC_LEVELSEQUENCER_Progress_OutBus = prog_q;
  assign CC_LEVELSEQUENCER_Banner_Out      = (state_q == S_BANNER);
  assign CC_LEVELSEQUENCER_LevelDone_Out   = ldone_q;
  assign CC_LEVELSEQUENCER_GameDone_Out    = gdone_q;

endmodule
